// File: rtl/pcie_symbol_aligner.sv
// Receive-lane symbol aligner: locates K28.5 commas in a raw 10-bit deserialised
// stream, acquires/maintains symbol lock and delivers boundary-aligned symbols.
module pcie_symbol_aligner #(
  parameter logic [3:0] LOCK_COMMAS = 4'd2,
  parameter logic [3:0] LOSS_COMMAS = 4'd4
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic [9:0] RxIn,
  input  logic       RxValid,
  input  logic       BitRev,
  output logic [9:0] AlignedOut,
  output logic       AlignedValid,
  output logic       CommaDet,
  output logic       Locked,
  output logic [3:0] Offset,
  output logic       RealignPulse
);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  function automatic logic [9:0] reverse10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) begin
      r[i] = v[9-i];
    end
    return r;
  endfunction

  function automatic logic is_k28_5(input logic [9:0] s);
    return (s == 10'h17C) || (s == 10'h283);
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  offset_r;
  logic [3:0]  offset_nx_s;
  logic [3:0]  lock_cnt_r;
  logic [3:0]  lock_cnt_nx_s;
  logic [3:0]  miss_cnt_r;
  logic [3:0]  miss_cnt_nx_s;
  logic [3:0]  lock_inc_s;
  logic [3:0]  miss_inc_s;
  logic [9:0]  prev_r;
  logic [9:0]  rx_s;
  logic [19:0] win_s;
  logic [9:0]  match_s;
  logic [3:0]  first_s;
  logic        any_s;
  logic        here_s;
  logic        realign_s;
  logic [9:0]  aligned_nx_s;
  logic [9:0]  aligned_out_r;
  logic        aligned_valid_r;
  logic        comma_det_r;
  logic        locked_r;
  logic        realign_r;

  assign rx_s         = BitRev ? reverse10(RxIn) : RxIn;
  assign win_s        = {rx_s, prev_r};
  assign any_s        = |match_s;
  assign here_s       = match_s[offset_r];
  assign aligned_nx_s = win_s[offset_nx_s +: 10];
  assign lock_inc_s   = (lock_cnt_r >= LOCK_COMMAS) ? LOCK_COMMAS : lock_cnt_r + 4'd1;
  assign miss_inc_s   = (miss_cnt_r >= LOSS_COMMAS) ? LOSS_COMMAS : miss_cnt_r + 4'd1;

  // Comma search over all ten phases; scanning downward leaves the lowest hit in first_s.
  always_comb begin
    match_s = 10'd0;
    first_s = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if ((win_s[k +: 7] == 7'b1111100) || (win_s[k +: 7] == 7'b0000011)) begin
        match_s[k] = 1'b1;
        first_s    = 4'(k);
      end else begin
        match_s[k] = 1'b0;
      end
    end
  end

  // Lock FSM next-state; a comma at the current offset always takes precedence.
  always_comb begin
    state_nx_s    = state_r;
    offset_nx_s   = offset_r;
    lock_cnt_nx_s = lock_cnt_r;
    miss_cnt_nx_s = miss_cnt_r;
    realign_s     = 1'b0;
    case (state_r)
      ST_UNLOCKED: begin
        if (any_s) begin
          offset_nx_s   = first_s;
          lock_cnt_nx_s = 4'd1;
          miss_cnt_nx_s = 4'd0;
          if (LOCK_COMMAS == 4'd1) begin
            state_nx_s = ST_LOCKED;
          end else begin
            state_nx_s = ST_CANDIDATE;
          end
        end else begin
          state_nx_s = ST_UNLOCKED;
        end
      end
      ST_CANDIDATE: begin
        if (here_s) begin
          lock_cnt_nx_s = lock_inc_s;
          if (lock_inc_s >= LOCK_COMMAS) begin
            state_nx_s    = ST_LOCKED;
            miss_cnt_nx_s = 4'd0;
          end else begin
            state_nx_s = ST_CANDIDATE;
          end
        end else if (any_s) begin
          offset_nx_s   = first_s;
          lock_cnt_nx_s = 4'd1;
        end else begin
          state_nx_s = ST_CANDIDATE;
        end
      end
      ST_LOCKED: begin
        if (here_s) begin
          miss_cnt_nx_s = 4'd0;
        end else if (any_s) begin
          if (miss_inc_s >= LOSS_COMMAS) begin
            state_nx_s    = ST_CANDIDATE;
            offset_nx_s   = first_s;
            lock_cnt_nx_s = 4'd1;
            miss_cnt_nx_s = 4'd0;
            realign_s     = 1'b1;
          end else begin
            miss_cnt_nx_s = miss_inc_s;
          end
        end else begin
          state_nx_s = ST_LOCKED;
        end
      end
      default: begin
        state_nx_s = ST_UNLOCKED;
      end
    endcase
  end

  // State and output registers; an idle RxValid cycle freezes everything but the strobes.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_r         <= ST_UNLOCKED;
      offset_r        <= 4'd0;
      lock_cnt_r      <= 4'd0;
      miss_cnt_r      <= 4'd0;
      prev_r          <= 10'd0;
      aligned_out_r   <= 10'd0;
      aligned_valid_r <= 1'b0;
      comma_det_r     <= 1'b0;
      locked_r        <= 1'b0;
      realign_r       <= 1'b0;
    end else if (RxValid) begin
      state_r         <= state_nx_s;
      offset_r        <= offset_nx_s;
      lock_cnt_r      <= lock_cnt_nx_s;
      miss_cnt_r      <= miss_cnt_nx_s;
      prev_r          <= rx_s;
      aligned_out_r   <= aligned_nx_s;
      aligned_valid_r <= (state_nx_s != ST_UNLOCKED);
      comma_det_r     <= (state_nx_s != ST_UNLOCKED) && is_k28_5(aligned_nx_s);
      locked_r        <= (state_nx_s == ST_LOCKED);
      realign_r       <= realign_s;
    end else begin
      aligned_valid_r <= 1'b0;
      comma_det_r     <= 1'b0;
      realign_r       <= 1'b0;
    end
  end

  assign AlignedOut   = aligned_out_r;
  assign AlignedValid = aligned_valid_r;
  assign CommaDet     = comma_det_r;
  assign Locked       = locked_r;
  assign Offset       = offset_r;
  assign RealignPulse = realign_r;

endmodule

// File: tb/tb_pcie_symbol_aligner.sv
// Bench for pcie_symbol_aligner: bit-level stream builder, rule-level reference
// model, directed lock/realign scenarios and a randomized model comparison.
`timescale 1ns/1ps
module tb_pcie_symbol_aligner;
  localparam int LOCKN = 2;
  localparam int LOSSN = 4;

  logic       Clk = 1'b0;
  logic       notReset = 1'b0;
  logic [9:0] RxIn = 10'd0;
  logic       RxValid = 1'b0;
  logic       BitRev = 1'b0;
  logic [9:0] AlignedOut;
  logic       AlignedValid, CommaDet, Locked, RealignPulse;
  logic [3:0] Offset;
  wire  [17:0] outs_w = {AlignedOut, AlignedValid, CommaDet, Locked, Offset, RealignPulse};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  pcie_symbol_aligner #(.LOCK_COMMAS(4'd2), .LOSS_COMMAS(4'd4)) dut (
    .Clk(Clk), .notReset(notReset), .RxIn(RxIn), .RxValid(RxValid), .BitRev(BitRev),
    .AlignedOut(AlignedOut), .AlignedValid(AlignedValid), .CommaDet(CommaDet),
    .Locked(Locked), .Offset(Offset), .RealignPulse(RealignPulse)
  );

  // reference model state (rule level, on the received bit order)
  logic [9:0] m_prev;
  bit m_sync, m_lock;
  int m_cnt, m_miss, m_off;
  logic [9:0] e_out;
  bit e_valid, e_comma, e_lock, e_pulse;

  // bit-level stream under construction, symbols placed in it, per-cycle history
  bit bq[$];
  logic [9:0] syms[$];
  logic [9:0] h_out[$];
  logic [3:0] h_off[$];
  bit h_valid[$], h_in_valid[$], h_lock[$], h_comma[$], h_pulse[$];

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  function automatic bit is_comma(input logic [9:0] s);
    return (s == 10'h17C) || (s == 10'h283);
  endfunction

  task automatic model_reset();
    m_prev = 10'd0; m_sync = 0; m_lock = 0; m_cnt = 0; m_miss = 0; m_off = 0;
    e_out = 10'd0; e_valid = 0; e_comma = 0; e_lock = 0; e_pulse = 0;
  endtask

  task automatic model_step(input bit valid, input logic [9:0] r);
    logic [19:0] w;
    logic [6:0]  pat;
    int first;
    bit here;
    if (!valid) begin
      e_valid = 0; e_comma = 0; e_pulse = 0;
      return;
    end
    w = {r, m_prev};
    m_prev = r;
    first = -1;
    here = 0;
    for (int k = 0; k < 10; k++) begin
      pat = 7'(w >> k);
      if (pat == 7'h7C || pat == 7'h03) begin
        if (first < 0) first = k;
        if (k == m_off) here = 1;
      end
    end
    e_pulse = 0;
    if (!m_sync) begin
      if (first >= 0) begin
        m_sync = 1; m_off = first; m_cnt = 1; m_miss = 0; m_lock = (LOCKN == 1);
      end
    end else if (!m_lock) begin
      if (here) begin
        m_cnt = (m_cnt + 1 > LOCKN) ? LOCKN : m_cnt + 1;
        if (m_cnt >= LOCKN) begin m_lock = 1; m_miss = 0; end
      end else if (first >= 0) begin
        m_off = first; m_cnt = 1;
      end
    end else begin
      if (here) m_miss = 0;
      else if (first >= 0) begin
        m_miss++;
        if (m_miss >= LOSSN) begin
          m_lock = 0; m_off = first; m_cnt = 1; m_miss = 0; e_pulse = 1;
        end
      end
    end
    e_out   = 10'(w >> m_off);
    e_valid = m_sync;
    e_comma = m_sync && is_comma(e_out);
    e_lock  = m_lock;
  endtask

  task automatic clear_all();
    bq.delete(); syms.delete();
    h_out.delete(); h_off.delete(); h_valid.delete(); h_in_valid.delete();
    h_lock.delete(); h_comma.delete(); h_pulse.delete();
  endtask

  task automatic do_reset(input bit rev);
    @(negedge Clk);
    notReset = 1'b0; RxValid = 1'b0; RxIn = 10'd0; BitRev = rev;
    model_reset();
    clear_all();
    @(negedge Clk);
    notReset = 1'b1;
  endtask

  task automatic step(input bit valid, input logic [9:0] word);
    @(negedge Clk);
    RxValid = valid; RxIn = word;
    @(posedge Clk);
    #1;
    model_step(valid, BitRev ? rev10(word) : word);
    h_in_valid.push_back(valid); h_valid.push_back(AlignedValid); h_out.push_back(AlignedOut);
    h_lock.push_back(Locked); h_off.push_back(Offset); h_comma.push_back(CommaDet);
    h_pulse.push_back(RealignPulse);
  endtask

  task automatic push_fill(input int n);
    for (int i = 0; i < n; i++) bq.push_back((i % 2) == 0);
  endtask

  task automatic add_sym(input logic [9:0] s);
    syms.push_back(s);
    for (int i = 0; i < 10; i++) bq.push_back(s[i]);
  endtask

  task automatic add_d();
    add_sym(($urandom_range(1, 0) == 1) ? 10'h2AA : 10'h155);
  endtask

  // serialise bq into words (bit0 first); optional idle cycle before every word
  task automatic send(input bit gaps, input bit rev);
    logic [9:0] w;
    if ((bq.size() % 10) != 0) push_fill(10 - (bq.size() % 10));
    while (bq.size() > 0) begin
      for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
      if (gaps) step(1'b0, 10'($urandom));
      step(1'b1, rev ? rev10(w) : w);
    end
  endtask

  task automatic build_std();
    push_fill(3);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) add_sym(10'h17C);
      else if (i % 4 == 2) add_sym(10'h283);
      else add_d();
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    notReset = 1'b0; BitRev = 1'b0; RxValid = 1'b0; RxIn = 10'd0;
    model_reset(); clear_all();
    #1;
    n_tests++;
    if (outs_w !== 18'd0) begin n_fail++; $display("FAIL reset_state got %h want 0", outs_w); end
    @(negedge Clk);
    notReset = 1'b1;
    push_fill(3); add_sym(10'h17C); add_d(); add_sym(10'h283); add_d(); add_sym(10'h17C); add_d();
    send(1'b0, 1'b0);
    n_tests++;
    if (Locked !== 1'b1) begin n_fail++; $display("FAIL reset_prelock got %b want 1", Locked); end
    #2 notReset = 1'b0;
    #1;
    n_tests++;
    if (outs_w !== 18'd0) begin n_fail++; $display("FAIL reset_midlock got %h want 0", outs_w); end
    model_reset(); clear_all();
    @(negedge Clk);
    notReset = 1'b1;
    push_fill(3);
    repeat (6) add_d();
    send(1'b0, 1'b0);
    for (int i = 0; i < h_lock.size(); i++) begin
      n_tests++;
      if ({h_lock[i], h_valid[i]} !== 2'b00) begin
        n_fail++; $display("FAIL reset_nolock cyc %0d got lock/valid %b%b want 00", i, h_lock[i], h_valid[i]);
      end
    end
    clear_all();
    push_fill(3); add_sym(10'h17C); add_d(); add_sym(10'h283); add_d();
    send(1'b0, 1'b0);
    n_tests++;
    if ({Locked, Offset} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL reset_relock got %b/%0d want 1/3", Locked, Offset);
    end
  endtask

  task automatic test_lock_offset3();
    logic [9:0] g_out[$];
    bit g_lock[$], g_comma[$];
    logic [3:0] g_off[$];
    do_reset(1'b0);
    build_std();
    send(1'b0, 1'b0);
    for (int i = 0; i < h_out.size(); i++)
      if (h_valid[i]) begin
        g_out.push_back(h_out[i]); g_lock.push_back(h_lock[i]);
        g_comma.push_back(h_comma[i]); g_off.push_back(h_off[i]);
      end
    n_tests++;
    if (g_out.size() != syms.size()) begin
      n_fail++; $display("FAIL lock3_count got %0d want %0d", g_out.size(), syms.size());
    end
    for (int i = 0; i < g_out.size() && i < syms.size(); i++) begin
      n_tests++;
      if ({g_out[i], g_comma[i], g_lock[i], g_off[i]} !== {syms[i], is_comma(syms[i]), i >= 2, 4'd3}) begin
        n_fail++;
        $display("FAIL lock3_sym %0d got %h/c%b/l%b/o%0d want %h/c%b/l%b/o3", i, g_out[i], g_comma[i],
                 g_lock[i], g_off[i], syms[i], is_comma(syms[i]), i >= 2);
      end
    end
  endtask

  task automatic test_rxvalid_gaps();
    logic [9:0] g_out[$];
    bit g_comma[$];
    do_reset(1'b0);
    build_std();
    send(1'b1, 1'b0);
    for (int i = 0; i < h_out.size(); i++) begin
      if (h_valid[i]) begin g_out.push_back(h_out[i]); g_comma.push_back(h_comma[i]); end
      if (!h_in_valid[i]) begin
        n_tests++;
        if (h_valid[i] !== 1'b0) begin n_fail++; $display("FAIL gaps_idle cyc %0d got valid 1 want 0", i); end
      end
    end
    n_tests++;
    if (g_out.size() != syms.size()) begin
      n_fail++; $display("FAIL gaps_count got %0d want %0d", g_out.size(), syms.size());
    end
    for (int i = 0; i < g_out.size() && i < syms.size(); i++) begin
      n_tests++;
      if ({g_out[i], g_comma[i]} !== {syms[i], is_comma(syms[i])}) begin
        n_fail++; $display("FAIL gaps_sym %0d got %h/%b want %h/%b", i, g_out[i], g_comma[i], syms[i], is_comma(syms[i]));
      end
    end
  endtask

  task automatic test_bitrev();
    logic [9:0] g_out[$];
    bit g_lock[$];
    logic [3:0] g_off[$];
    int k;
    do_reset(1'b1);
    build_std();
    send(1'b0, 1'b1);
    for (int i = 0; i < h_out.size(); i++)
      if (h_valid[i]) begin g_out.push_back(h_out[i]); g_lock.push_back(h_lock[i]); end
    n_tests++;
    if (g_out.size() != syms.size()) begin
      n_fail++; $display("FAIL bitrev_count got %0d want %0d", g_out.size(), syms.size());
    end
    for (int i = 0; i < g_out.size() && i < syms.size(); i++) begin
      n_tests++;
      if ({g_out[i], g_lock[i]} !== {syms[i], i >= 2}) begin
        n_fail++; $display("FAIL bitrev_sym %0d got %h/%b want %h/%b", i, g_out[i], g_lock[i], syms[i], i >= 2);
      end
    end
    // candidate at offset 5, then a comma at offset 2 must restart the count
    do_reset(1'b1);
    push_fill(5); add_sym(10'h17C); add_sym(10'h2AA);
    push_fill(7); add_sym(10'h283); add_sym(10'h2AA); add_sym(10'h17C); add_sym(10'h2AA); add_sym(10'h155);
    send(1'b0, 1'b1);
    g_out.delete(); g_lock.delete();
    for (int i = 0; i < h_out.size(); i++)
      if (h_valid[i]) begin g_out.push_back(h_out[i]); g_lock.push_back(h_lock[i]); g_off.push_back(h_off[i]); end
    k = 0;
    while (k < g_out.size() && g_out[k] != 10'h17C) k++;
    n_tests++;
    if (k >= g_out.size() || {g_lock[k], g_off[k]} !== {1'b0, 4'd5}) begin
      n_fail++; $display("FAIL cand5 got idx %0d want first comma at offset 5 unlocked", k);
    end
    while (k < g_out.size() && g_out[k] != 10'h283) k++;
    n_tests++;
    if (k >= g_out.size() || {g_lock[k], g_off[k]} !== {1'b0, 4'd2}) begin
      n_fail++; $display("FAIL cand2 got idx %0d want comma at offset 2 unlocked", k);
    end
    while (k < g_out.size() && g_out[k] != 10'h17C) k++;
    n_tests++;
    if (k >= g_out.size() || {g_lock[k], g_off[k]} !== {1'b1, 4'd2}) begin
      n_fail++; $display("FAIL cand2_lock got idx %0d want lock at offset 2", k);
    end
  endtask

  task automatic test_foreign_minority();
    int first_lock, pulses, drops;
    do_reset(1'b0);
    push_fill(3); add_sym(10'h17C); add_d(); add_sym(10'h283); add_d(); add_d();
    push_fill(4); add_sym(10'h17C); add_d(); add_sym(10'h283); add_d(); add_sym(10'h17C); add_d();
    push_fill(6); add_sym(10'h283); add_d(); add_d();
    send(1'b0, 1'b0);
    first_lock = -1; pulses = 0; drops = 0;
    for (int i = 0; i < h_lock.size(); i++) begin
      pulses += int'(h_pulse[i]);
      if (first_lock < 0) begin
        if (h_lock[i]) first_lock = i;
      end else if (!h_lock[i] || h_off[i] != 4'd3) drops++;
    end
    n_tests++;
    if (first_lock < 0) begin n_fail++; $display("FAIL minority_lock got never locked want locked"); end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL minority_pulse got %0d pulses want 0", pulses); end
    n_tests++;
    if (drops != 0) begin n_fail++; $display("FAIL minority_hold got %0d lost cycles want 0", drops); end
    n_tests++;
    if ({Locked, Offset} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL minority_end got %b/%0d want 1/3", Locked, Offset);
    end
  endtask

  task automatic test_realign();
    int p, pulses, q;
    do_reset(1'b0);
    push_fill(3); add_sym(10'h17C); add_d(); add_sym(10'h283); add_d();
    push_fill(4);
    for (int i = 0; i < 2; i++) begin add_sym(10'h17C); add_d(); add_sym(10'h283); add_d(); end
    add_sym(10'h17C); add_d(); add_d();
    send(1'b0, 1'b0);
    p = -1; pulses = 0;
    for (int i = 0; i < h_pulse.size(); i++)
      if (h_pulse[i]) begin pulses++; if (p < 0) p = i; end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL realign_pulses got %0d want 1", pulses); end
    if (p > 0) begin
      n_tests++;
      if ({h_lock[p], h_off[p], h_out[p]} !== {1'b0, 4'd7, 10'h283}) begin
        n_fail++; $display("FAIL realign_at got %b/%0d/%h want 0/7/283", h_lock[p], h_off[p], h_out[p]);
      end
      n_tests++;
      if ({h_lock[p-1], h_off[p-1]} !== {1'b1, 4'd3}) begin
        n_fail++; $display("FAIL realign_before got %b/%0d want 1/3", h_lock[p-1], h_off[p-1]);
      end
      q = p + 1;
      while (q < h_lock.size() && !h_lock[q]) q++;
      n_tests++;
      if (q >= h_lock.size() || h_out[q] !== 10'h17C) begin
        n_fail++; $display("FAIL realign_relock got idx %0d want relock on next comma", q);
      end
    end
    n_tests++;
    if ({Locked, Offset} !== {1'b1, 4'd7}) begin
      n_fail++; $display("FAIL realign_end got %b/%0d want 1/7", Locked, Offset);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 2; run++) begin
      do_reset(run == 1);
      for (int c = 0; c < 900; c++) begin
        step($urandom_range(3, 0) != 0, 10'($urandom));
        n_tests++;
        if (outs_w !== {e_out, e_valid, e_comma, e_lock, 4'(m_off), e_pulse}) begin
          n_fail++;
          if (n_fail < 20)
            $display("FAIL random run %0d cyc %0d got %h want %h", run, c, outs_w,
                     {e_out, e_valid, e_comma, e_lock, 4'(m_off), e_pulse});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_offset3();
    test_foreign_minority();
    test_realign();
    test_rxvalid_gaps();
    test_bitrev();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
